// File: rtl/reorder_buffer_pkg.sv
// Shared opcode encodings, commit FSM states and small helpers for the reorder buffer.
package reorder_buffer_pkg;

  localparam int unsigned DefaultDepth = 32;
  localparam int unsigned OpW          = 6;

  localparam logic [OpW-1:0] OpAdd  = 6'd1;
  localparam logic [OpW-1:0] OpBeq  = 6'd10;
  localparam logic [OpW-1:0] OpBne  = 6'd11;
  localparam logic [OpW-1:0] OpBlt  = 6'd12;
  localparam logic [OpW-1:0] OpBge  = 6'd13;
  localparam logic [OpW-1:0] OpBltu = 6'd14;
  localparam logic [OpW-1:0] OpBgeu = 6'd15;
  localparam logic [OpW-1:0] OpSb   = 6'd20;
  localparam logic [OpW-1:0] OpSh   = 6'd21;
  localparam logic [OpW-1:0] OpSw   = 6'd22;

  typedef enum logic [0:0] {
    StIdle,
    StStoreWait
  } commit_state_e;

  function automatic logic mispredicted(input logic [31:0] next_pc, input logic [31:0] pred_pc);
    return next_pc != pred_pc;
  endfunction

  function automatic logic branch_taken(input logic [31:0] pc, input logic [31:0] next_pc);
    return next_pc != (pc + 32'd4);
  endfunction

endpackage

// File: rtl/reorder_buffer_ptr.sv
// Wrapping ring pointer with increment and synchronous clear; used for ROB head and tail.
module rob_ptr #(
  parameter int unsigned IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             inc,
  input  logic             clr,
  output logic [IDX_W-1:0] ptr
);

  logic [IDX_W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = ptr_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (en) begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/reorder_buffer.sv
// In-order-retire reorder buffer: multi-port write-back, store commit handshake and
// registered flush with redirect PC on mispredict.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int unsigned DEPTH  = DefaultDepth,
  parameter int unsigned IDX_W  = $clog2(DEPTH),
  parameter int unsigned NUM_WB = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rdy,
  input  logic                  issue_valid,
  input  logic [5:0]            issue_op,
  input  logic [4:0]            issue_rd,
  input  logic                  issue_is_store,
  input  logic                  issue_is_branch,
  input  logic [31:0]           issue_pc,
  input  logic [31:0]           issue_pred_pc,
  output logic [IDX_W-1:0]      issue_tag,
  output logic                  full,
  output logic [IDX_W:0]        count,
  input  logic [NUM_WB-1:0]     wb_valid,
  input  logic [NUM_WB*IDX_W-1:0] wb_tag,
  input  logic [NUM_WB*32-1:0]  wb_value,
  input  logic [NUM_WB*32-1:0]  wb_addr,
  input  logic [NUM_WB*32-1:0]  wb_next_pc,
  output logic                  commit_valid,
  output logic [IDX_W-1:0]      commit_tag,
  output logic [4:0]            commit_rd,
  output logic [31:0]           commit_value,
  output logic                  store_req,
  output logic [5:0]            store_op,
  output logic [31:0]           store_addr,
  output logic [31:0]           store_data,
  input  logic                  store_ack,
  output logic                  bp_update,
  output logic [31:0]           bp_pc,
  output logic                  bp_taken,
  output logic [31:0]           bp_target,
  output logic                  flush,
  output logic [31:0]           flush_pc
);

  logic [DEPTH-1:0] valid_q, ready_q, is_store_q, is_branch_q;
  logic [5:0]       op_q      [DEPTH];
  logic [4:0]       rd_q      [DEPTH];
  logic [31:0]      pc_q      [DEPTH];
  logic [31:0]      pred_pc_q [DEPTH];
  logic [31:0]      value_q   [DEPTH];
  logic [31:0]      addr_q    [DEPTH];
  logic [31:0]      next_pc_q [DEPTH];

  logic [IDX_W-1:0] head, tail;
  logic [IDX_W:0]   count_q, count_d;
  logic [IDX_W-1:0] wb_idx [NUM_WB];
  logic [NUM_WB-1:0] wb_hit;
  logic             issue_fire, retire, clear, head_ok;
  commit_state_e    state_q, state_d;

  logic             commit_valid_q, commit_valid_d;
  logic [IDX_W-1:0] commit_tag_q, commit_tag_d;
  logic [4:0]       commit_rd_q, commit_rd_d;
  logic [31:0]      commit_value_q, commit_value_d;
  logic             store_req_q, store_req_d;
  logic [5:0]       store_op_q, store_op_d;
  logic [31:0]      store_addr_q, store_addr_d, store_data_q, store_data_d;
  logic             bp_update_q, bp_update_d, bp_taken_q, bp_taken_d;
  logic [31:0]      bp_pc_q, bp_pc_d, bp_target_q, bp_target_d;
  logic             flush_q, flush_d;
  logic [31:0]      flush_pc_q, flush_pc_d;

  assign full       = (count_q == (IDX_W+1)'(DEPTH));
  assign issue_fire = issue_valid && !full && !flush_q;
  assign head_ok    = valid_q[head] && ready_q[head];

  for (genvar g = 0; g < NUM_WB; g++) begin : g_wb
    assign wb_idx[g] = wb_tag[g*IDX_W +: IDX_W];
    assign wb_hit[g] = wb_valid[g] && valid_q[wb_idx[g]];
  end

  rob_ptr #(.IDX_W(IDX_W)) u_head (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (rdy),
    .inc   (retire),
    .clr   (clear),
    .ptr   (head)
  );

  rob_ptr #(.IDX_W(IDX_W)) u_tail (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (rdy),
    .inc   (issue_fire),
    .clr   (clear),
    .ptr   (tail)
  );

  always_comb begin
    state_d        = state_q;
    retire         = 1'b0;
    clear          = 1'b0;
    commit_valid_d = 1'b0;
    commit_tag_d   = commit_tag_q;
    commit_rd_d    = commit_rd_q;
    commit_value_d = commit_value_q;
    store_req_d    = store_req_q;
    store_op_d     = store_op_q;
    store_addr_d   = store_addr_q;
    store_data_d   = store_data_q;
    bp_update_d    = 1'b0;
    bp_pc_d        = bp_pc_q;
    bp_taken_d     = bp_taken_q;
    bp_target_d    = bp_target_q;
    flush_d        = 1'b0;
    flush_pc_d     = flush_pc_q;
    unique case (state_q)
      StIdle: begin
        if (head_ok) begin
          if (is_store_q[head]) begin
            // The store stays at head until memory accepts it.
            store_req_d  = 1'b1;
            store_op_d   = op_q[head];
            store_addr_d = addr_q[head];
            store_data_d = value_q[head];
            state_d      = StStoreWait;
          end else begin
            retire         = 1'b1;
            commit_valid_d = 1'b1;
            commit_tag_d   = head;
            commit_rd_d    = rd_q[head];
            commit_value_d = value_q[head];
            if (is_branch_q[head]) begin
              bp_update_d = 1'b1;
              bp_pc_d     = pc_q[head];
              bp_taken_d  = branch_taken(pc_q[head], next_pc_q[head]);
              bp_target_d = next_pc_q[head];
            end
            if (mispredicted(next_pc_q[head], pred_pc_q[head])) begin
              clear      = 1'b1;
              flush_d    = 1'b1;
              flush_pc_d = next_pc_q[head];
            end
          end
        end
      end
      StStoreWait: begin
        if (store_ack) begin
          retire      = 1'b1;
          store_req_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else begin
      count_d = count_q + (IDX_W+1)'(issue_fire) - (IDX_W+1)'(retire);
    end
  end

  // Walk ports from high to low so the lowest-indexed port wins a tag collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      ready_q <= '0;
    end else if (rdy) begin
      if (clear) begin
        valid_q <= '0;
        ready_q <= '0;
      end else begin
        if (issue_fire) begin
          valid_q[tail] <= 1'b1;
          ready_q[tail] <= 1'b0;
        end
        for (int p = NUM_WB - 1; p >= 0; p--) begin
          if (wb_hit[p]) ready_q[wb_idx[p]] <= 1'b1;
        end
        if (retire) valid_q[head] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rdy) begin
      if (issue_fire) begin
        op_q[tail]        <= issue_op;
        rd_q[tail]        <= issue_rd;
        is_store_q[tail]  <= issue_is_store;
        is_branch_q[tail] <= issue_is_branch;
        pc_q[tail]        <= issue_pc;
        pred_pc_q[tail]   <= issue_pred_pc;
      end
      for (int p = NUM_WB - 1; p >= 0; p--) begin
        if (wb_hit[p]) begin
          value_q[wb_idx[p]]   <= wb_value[p*32 +: 32];
          addr_q[wb_idx[p]]    <= wb_addr[p*32 +: 32];
          next_pc_q[wb_idx[p]] <= wb_next_pc[p*32 +: 32];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      count_q        <= '0;
      commit_valid_q <= 1'b0;
      commit_tag_q   <= '0;
      commit_rd_q    <= '0;
      commit_value_q <= '0;
      store_req_q    <= 1'b0;
      store_op_q     <= '0;
      store_addr_q   <= '0;
      store_data_q   <= '0;
      bp_update_q    <= 1'b0;
      bp_pc_q        <= '0;
      bp_taken_q     <= 1'b0;
      bp_target_q    <= '0;
      flush_q        <= 1'b0;
      flush_pc_q     <= '0;
    end else if (rdy) begin
      state_q        <= state_d;
      count_q        <= count_d;
      commit_valid_q <= commit_valid_d;
      commit_tag_q   <= commit_tag_d;
      commit_rd_q    <= commit_rd_d;
      commit_value_q <= commit_value_d;
      store_req_q    <= store_req_d;
      store_op_q     <= store_op_d;
      store_addr_q   <= store_addr_d;
      store_data_q   <= store_data_d;
      bp_update_q    <= bp_update_d;
      bp_pc_q        <= bp_pc_d;
      bp_taken_q     <= bp_taken_d;
      bp_target_q    <= bp_target_d;
      flush_q        <= flush_d;
      flush_pc_q     <= flush_pc_d;
    end
  end

  assign issue_tag    = tail;
  assign count        = count_q;
  assign commit_valid = commit_valid_q;
  assign commit_tag   = commit_tag_q;
  assign commit_rd    = commit_rd_q;
  assign commit_value = commit_value_q;
  assign store_req    = store_req_q;
  assign store_op     = store_op_q;
  assign store_addr   = store_addr_q;
  assign store_data   = store_data_q;
  assign bp_update    = bp_update_q;
  assign bp_pc        = bp_pc_q;
  assign bp_taken     = bp_taken_q;
  assign bp_target    = bp_target_q;
  assign flush        = flush_q;
  assign flush_pc     = flush_pc_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: expected commits queued at issue, popped on commit_valid.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  localparam int DEPTH  = 32;
  localparam int IDX_W  = 5;
  localparam int NUM_WB = 3;

  logic                    clk;
  logic                    rst_n, rdy;
  logic                    issue_valid, issue_is_store, issue_is_branch;
  logic [5:0]              issue_op;
  logic [4:0]              issue_rd;
  logic [31:0]             issue_pc, issue_pred_pc;
  logic [IDX_W-1:0]        issue_tag;
  logic                    full;
  logic [IDX_W:0]          count;
  logic [NUM_WB-1:0]       wb_valid;
  logic [NUM_WB*IDX_W-1:0] wb_tag;
  logic [NUM_WB*32-1:0]    wb_value, wb_addr, wb_next_pc;
  logic                    commit_valid;
  logic [IDX_W-1:0]        commit_tag;
  logic [4:0]              commit_rd;
  logic [31:0]             commit_value;
  logic                    store_req, store_ack;
  logic [5:0]              store_op;
  logic [31:0]             store_addr, store_data;
  logic                    bp_update, bp_taken, flush;
  logic [31:0]             bp_pc, bp_target, flush_pc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  reorder_buffer #(.DEPTH(DEPTH), .IDX_W(IDX_W), .NUM_WB(NUM_WB)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy),
    .issue_valid(issue_valid), .issue_op(issue_op), .issue_rd(issue_rd),
    .issue_is_store(issue_is_store), .issue_is_branch(issue_is_branch),
    .issue_pc(issue_pc), .issue_pred_pc(issue_pred_pc),
    .issue_tag(issue_tag), .full(full), .count(count),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value), .wb_addr(wb_addr),
    .wb_next_pc(wb_next_pc),
    .commit_valid(commit_valid), .commit_tag(commit_tag), .commit_rd(commit_rd),
    .commit_value(commit_value),
    .store_req(store_req), .store_op(store_op), .store_addr(store_addr),
    .store_data(store_data), .store_ack(store_ack),
    .bp_update(bp_update), .bp_pc(bp_pc), .bp_taken(bp_taken), .bp_target(bp_target),
    .flush(flush), .flush_pc(flush_pc)
  );

  typedef struct packed {
    logic [IDX_W-1:0] tag;
    logic [4:0]       rd;
    logic [31:0]      value;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   errors   = 0;
  int   exp_tail = 0;

  always @(negedge clk) begin
    if (rst_n && commit_valid) begin : mon
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL commit_unexpected got tag=%0d value=%h, required no commit",
                 commit_tag, commit_value);
      end else begin
        e = exp_q.pop_front();
        if (commit_tag !== e.tag || commit_rd !== e.rd || commit_value !== e.value) begin
          errors++;
          $display("FAIL commit got tag=%0d rd=%0d value=%h, required tag=%0d rd=%0d value=%h",
                   commit_tag, commit_rd, commit_value, e.tag, e.rd, e.value);
        end
      end
    end
  end

  function automatic logic [31:0] pc_of(input int tag);
    return 32'h1000 + 32'(tag) * 32'd4;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_issue(input logic [5:0] op, input logic [4:0] rd, input logic st,
                          input logic br, input logic [31:0] pc, input logic [31:0] pred);
    issue_valid = 1'b1; issue_op = op; issue_rd = rd;
    issue_is_store = st; issue_is_branch = br; issue_pc = pc; issue_pred_pc = pred;
    checks++;
    if (issue_tag !== IDX_W'(exp_tail)) begin
      errors++;
      $display("FAIL issue_tag got %0d required %0d", issue_tag, exp_tail);
    end
    tick();
    issue_valid = 1'b0;
    exp_tail = (exp_tail + 1) % DEPTH;
  endtask

  task automatic set_wb(input int p, input int tag, input logic [31:0] val,
                        input logic [31:0] addr, input logic [31:0] npc);
    wb_valid[p]                 = 1'b1;
    wb_tag[p*IDX_W +: IDX_W]    = IDX_W'(tag);
    wb_value[p*32 +: 32]        = val;
    wb_addr[p*32 +: 32]         = addr;
    wb_next_pc[p*32 +: 32]      = npc;
  endtask

  task automatic clear_wb();
    wb_valid = '0;
  endtask

  task automatic drain(input string name);
    for (int c = 0; c < 100 && exp_q.size() != 0; c++) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain got %0d commits outstanding, required 0", name, exp_q.size());
    end
    checks++;
    if (count !== '0) begin
      errors++;
      $display("FAIL %s_count got %0d required 0", name, count);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({commit_valid, store_req, bp_update, flush, full, count, issue_tag} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got cv=%b sr=%b bp=%b fl=%b full=%b count=%0d tag=%0d, required 0",
               commit_valid, store_req, bp_update, flush, full, count, issue_tag);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (count !== '0 || full !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got count=%0d full=%b required 0/0", count, full);
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < DEPTH; i++) begin
      logic [4:0] rd;
      rd = 5'((i % 31) + 1);
      exp_q.push_back({IDX_W'(i), rd, 32'(i * 3)});
      do_issue(OpAdd, rd, 1'b0, 1'b0, pc_of(i), pc_of(i) + 32'd4);
    end
    checks++;
    if (full !== 1'b1 || count !== 6'd32) begin
      errors++;
      $display("FAIL fill_full got full=%b count=%0d required 1/32", full, count);
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      set_wb(i % NUM_WB, i, 32'(i * 3), 32'h0, pc_of(i) + 32'd4);
      tick();
      clear_wb();
    end
    drain("fill");
  endtask

  task automatic test_mispredict();
    for (int k = 0; k < 6; k++) begin
      logic [31:0] pc;
      pc = 32'hF8 + 32'(k) * 32'd4;
      if (k < 3) exp_q.push_back({IDX_W'(k), 5'(k + 1), 32'h50 + 32'(k)});
      do_issue((k == 2) ? OpBeq : OpAdd, 5'(k + 1), 1'b0, k == 2, pc, pc + 32'd4);
    end
    for (int k = 3; k < 6; k++) set_wb(k - 3, k, 32'h50 + 32'(k), 32'h0, 32'hF8 + 32'(k) * 4 + 4);
    tick();
    clear_wb();
    set_wb(0, 0, 32'h50, 32'h0, 32'hFC);
    set_wb(1, 1, 32'h51, 32'h0, 32'h100);
    set_wb(2, 2, 32'h52, 32'h0, 32'h200);
    tick();
    clear_wb();
    for (int c = 0; c < 20 && flush !== 1'b1; c++) tick();
    checks++;
    if (flush !== 1'b1) begin
      errors++;
      $display("FAIL mispredict_flush got flush=%b required 1", flush);
    end
    checks++;
    if ({bp_update, bp_taken, bp_pc, bp_target} !== {2'b11, 32'h100, 32'h200}) begin
      errors++;
      $display("FAIL mispredict_bp got upd=%b taken=%b pc=%h tgt=%h required 1/1/100/200",
               bp_update, bp_taken, bp_pc, bp_target);
    end
    checks++;
    if (flush_pc !== 32'h200 || commit_valid !== 1'b1 || commit_tag !== 5'd2) begin
      errors++;
      $display("FAIL mispredict_redirect got flush_pc=%h cv=%b tag=%0d required 200/1/2",
               flush_pc, commit_valid, commit_tag);
    end
    issue_valid = 1'b1;
    tick();
    issue_valid = 1'b0;
    checks++;
    if ({flush, bp_update, count, issue_tag} !== '0) begin
      errors++;
      $display("FAIL mispredict_after got flush=%b bp=%b count=%0d tag=%0d required all 0",
               flush, bp_update, count, issue_tag);
    end
    exp_tail = 0;
    repeat (5) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL mispredict_commits got %0d outstanding required 0", exp_q.size());
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 40; i++) begin
      int t;
      logic [4:0] rd;
      t  = i % DEPTH;
      rd = 5'((i % 31) + 1);
      exp_q.push_back({IDX_W'(t), rd, 32'(i) + 32'h100});
      if (i > 0) set_wb(i % NUM_WB, (i - 1) % DEPTH, 32'(i - 1) + 32'h100, 32'h0,
                        pc_of((i - 1) % DEPTH) + 32'd4);
      do_issue(OpAdd, rd, 1'b0, 1'b0, pc_of(t), pc_of(t) + 32'd4);
      clear_wb();
      checks++;
      if (full !== 1'b0) begin
        errors++;
        $display("FAIL wrap_full got %b required 0 at i=%0d", full, i);
      end
    end
    set_wb(0, 39 % DEPTH, 32'd39 + 32'h100, 32'h0, pc_of(39 % DEPTH) + 32'd4);
    tick();
    clear_wb();
    drain("wrap");
  endtask

  task automatic test_same_cycle();
    int base;
    base = exp_tail;
    for (int j = 0; j < 31; j++) begin
      int t;
      t = (base + j) % DEPTH;
      exp_q.push_back({IDX_W'(t), 5'(j + 1), 32'h700 + 32'(j)});
      do_issue(OpAdd, 5'(j + 1), 1'b0, 1'b0, pc_of(t), pc_of(t) + 32'd4);
    end
    checks++;
    if (count !== 6'd31 || full !== 1'b0) begin
      errors++;
      $display("FAIL same_fill got count=%0d full=%b required 31/0", count, full);
    end
    set_wb(0, base, 32'h700, 32'h0, pc_of(base) + 32'd4);
    set_wb(1, exp_tail, 32'hBAD0BAD0, 32'h0, 32'h0);
    tick();
    clear_wb();
    exp_q.push_back({IDX_W'(exp_tail), 5'd7, 32'h71F});
    do_issue(OpAdd, 5'd7, 1'b0, 1'b0, pc_of(exp_tail), pc_of(exp_tail) + 32'd4);
    checks++;
    if (count !== 6'd31 || commit_valid !== 1'b1 || commit_tag !== IDX_W'(base)) begin
      errors++;
      $display("FAIL same_cycle got count=%0d cv=%b tag=%0d required 31/1/%0d",
               count, commit_valid, commit_tag, base);
    end
    for (int j = 1; j < 32; j += NUM_WB) begin
      for (int k = 0; k < NUM_WB && j + k < 32; k++) begin
        set_wb(k, (base + j + k) % DEPTH, 32'h700 + 32'(j + k), 32'h0,
               pc_of((base + j + k) % DEPTH) + 32'd4);
      end
      tick();
      clear_wb();
    end
    drain("same");
  endtask

  task automatic test_store();
    int base;
    base = exp_tail;
    do_issue(OpSw, 5'd0, 1'b1, 1'b0, pc_of(base), pc_of(base) + 32'd4);
    set_wb(2, base, 32'hDEADBEEF, 32'h8000_0040, pc_of(base) + 32'd4);
    tick();
    clear_wb();
    tick();
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({store_req, store_op, store_addr, store_data} !==
          {1'b1, OpSw, 32'h8000_0040, 32'hDEADBEEF}) begin
        errors++;
        $display("FAIL store_hold cycle %0d got req=%b op=%0d addr=%h data=%h", c,
                 store_req, store_op, store_addr, store_data);
      end
      checks++;
      if (count !== 6'd1) begin
        errors++;
        $display("FAIL store_count cycle %0d got %0d required 1", c, count);
      end
      tick();
    end
    store_ack = 1'b1;
    tick();
    store_ack = 1'b0;
    checks++;
    if (store_req !== 1'b0 || count !== '0) begin
      errors++;
      $display("FAIL store_ack got req=%b count=%0d required 0/0", store_req, count);
    end
  endtask

  task automatic test_reset_mid_store();
    int base;
    base = exp_tail;
    do_issue(OpSb, 5'd0, 1'b1, 1'b0, pc_of(base), pc_of(base) + 32'd4);
    set_wb(1, base, 32'h1234_5678, 32'h9000, pc_of(base) + 32'd4);
    tick();
    clear_wb();
    for (int c = 0; c < 10 && store_req !== 1'b1; c++) tick();
    checks++;
    if (store_req !== 1'b1) begin
      errors++;
      $display("FAIL rst_store_req got %b required 1", store_req);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({store_req, commit_valid, bp_update, flush, full, count, store_addr, store_data,
         store_op, issue_tag} !== '0) begin
      errors++;
      $display("FAIL rst_mid_store got req=%b count=%0d addr=%h data=%h tag=%0d required 0",
               store_req, count, store_addr, store_data, issue_tag);
    end
    exp_q.delete();
    exp_tail = 0;
    @(negedge clk);
    rst_n = 1'b1;
    do_issue(OpAdd, 5'd3, 1'b0, 1'b0, pc_of(0), pc_of(0) + 32'd4);
    checks++;
    if (count !== 6'd1) begin
      errors++;
      $display("FAIL rst_fresh_issue got count=%0d required 1", count);
    end
    rdy = 1'b0;
    issue_valid = 1'b1;
    set_wb(0, 0, 32'hBAD, 32'h0, pc_of(0) + 32'd4);
    repeat (3) tick();
    checks++;
    if (count !== 6'd1 || issue_tag !== 5'd1 || commit_valid !== 1'b0) begin
      errors++;
      $display("FAIL freeze got count=%0d tag=%0d cv=%b required 1/1/0",
               count, issue_tag, commit_valid);
    end
    issue_valid = 1'b0;
    clear_wb();
    rdy = 1'b1;
    exp_q.push_back({IDX_W'(0), 5'd3, 32'h55});
    set_wb(0, 0, 32'h55, 32'h0, pc_of(0) + 32'd4);
    tick();
    clear_wb();
    drain("freeze");
  endtask

  initial begin
    rst_n = 1'b0; rdy = 1'b1; store_ack = 1'b0;
    issue_valid = 1'b0; issue_op = '0; issue_rd = '0;
    issue_is_store = 1'b0; issue_is_branch = 1'b0; issue_pc = '0; issue_pred_pc = '0;
    wb_valid = '0; wb_tag = '0; wb_value = '0; wb_addr = '0; wb_next_pc = '0;
    test_reset();
    test_fill_drain();
    test_mispredict();
    test_wrap();
    test_same_cycle();
    test_store();
    test_reset_mid_store();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
